pwm_bank: RTL

Parametrised multi-channel PWM generator; successor to the single-channel PWM block. It drives NUM_CH outputs from one shared period counter, with per-channel duty, enable and polarity. Settings are double-buffered and applied only at a period boundary, so the LED, digit and PMOD pins never glitch. It sits beside the AXI config registers, which supply the settings and the load strobe, and feeds the top-level output muxes.

---
 rtl/pwm_bank_pkg.sv | 12 +
 rtl/pwm_bank_channel.sv | 37 +++
 rtl/pwm_bank.sv | 67 ++++++
 3 files changed

// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg: shared defaults and per-channel configuration record for pwm_bank.
package pwm_bank_pkg;
  localparam int DEF_NUM_CH = 16;
  localparam int DEF_CNT_WIDTH = 32;
  // Duty is stored at the widest supported width so one struct serves every CNT_WIDTH up to 32.
  localparam int MAX_CNT_WIDTH = 32;
  typedef struct packed {
    logic [MAX_CNT_WIDTH-1:0] duty;
    logic                     en;
    logic                     inv;
  } ch_cfg_t;
endpackage

// File: rtl/pwm_bank_channel.sv
// pwm_bank_channel: one channel's shadow/active config, duty compare and registered output.
module pwm_bank_channel
  import pwm_bank_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic [CNT_WIDTH-1:0] duty_i,
  input  logic                 en_i,
  input  logic                 inv_i,
  input  logic                 load_i,
  input  logic                 transfer_i,
  input  logic                 run_i,
  output logic                 pwm_o
);
  ch_cfg_t shd_q, shd_d, act_q, act_d;
  logic    pwm_q, pwm_d;
  always_comb begin
    shd_d = load_i ? ch_cfg_t'{duty: MAX_CNT_WIDTH'(duty_i), en: en_i, inv: inv_i} : shd_q;
    act_d = transfer_i ? shd_q : act_q;
    pwm_d = run_i & act_q.en & ((MAX_CNT_WIDTH'(cnt_i) < act_q.duty) ^ act_q.inv);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shd_q <= '0;
      act_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      shd_q <= shd_d;
      act_q <= act_d;
      pwm_q <= pwm_d;
    end
  end
  assign pwm_o = pwm_q;
endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM from one shared period counter with double-buffered settings
// that only take effect at a period boundary.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CNT_WIDTH-1:0]        period,
  input  logic [NUM_CH*CNT_WIDTH-1:0] duty,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic [NUM_CH-1:0]           ch_inv,
  input  logic                        load,
  output logic [NUM_CH-1:0]           pwm_out,
  output logic                        period_start,
  output logic                        update_pending,
  output logic [CNT_WIDTH-1:0]        cnt
);
  logic [CNT_WIDTH-1:0] per_shd_q, per_shd_d, per_act_q, per_act_d, cnt_q, cnt_d;
  logic                 pend_q, pend_d, pstart_q, pstart_d;
  logic                 run, boundary, transfer;
  // A stopped counter counts as a boundary every cycle, so a pending load applies at once.
  always_comb begin
    run       = per_act_q != '0;
    boundary  = !run || (cnt_q == per_act_q - CNT_WIDTH'(1));
    transfer  = boundary & pend_q;
    cnt_d     = boundary ? '0 : cnt_q + CNT_WIDTH'(1);
    per_shd_d = load ? period : per_shd_q;
    per_act_d = transfer ? per_shd_q : per_act_q;
    pend_d    = load | (pend_q & !boundary);
    pstart_d  = run & (cnt_q == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      per_shd_q <= '0;
      per_act_q <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      pstart_q  <= 1'b0;
    end else begin
      per_shd_q <= per_shd_d;
      per_act_q <= per_act_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pstart_q  <= pstart_d;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_bank_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .cnt_i     (cnt_q),
      .duty_i    (duty[i*CNT_WIDTH +: CNT_WIDTH]),
      .en_i      (ch_en[i]),
      .inv_i     (ch_inv[i]),
      .load_i    (load),
      .transfer_i(transfer),
      .run_i     (run),
      .pwm_o     (pwm_out[i])
    );
  end
  assign period_start   = pstart_q;
  assign update_pending = pend_q;
  assign cnt            = cnt_q;
endmodule
